uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter: MSG_A_LEN, 4, byte count of message A ("POLO").
REQ-002 SHALL have parameter: HDR_B, 8'h53, header byte ('S') of message B.
REQ-003 SHALL have port: clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: req_a  input  1  request message A (one-cycle pulse, e.g. MARCO match).
REQ-006 SHALL have port: req_b  input  1  request message B (status report pulse).
REQ-007 SHALL have port: status_byte  input  8  payload of message B.
REQ-008 SHALL have port: tx_busy  input  1  busy flag from the byte-wide UART transmitter.
REQ-009 SHALL have port: tx_data  output  8  byte presented to the transmitter.
REQ-010 SHALL have port: tx_start  output  1  one-cycle send strobe to the transmitter.
REQ-011 SHALL have port: grant  output  2  one-hot current owner ({B,A}); 2'b00 when idle.
REQ-012 SHALL have port: overflow  output  1  sticky flag: a request arrived while the same requester was already pending.

Function
REQ-013 SHALL hold one pending bit per requester, set on its req pulse and cleared when its message transmission completes.
REQ-014 SHALL treat a req pulse arriving while that requester is pending or granted as dropped, and set overflow.
REQ-015 SHALL implement FSM states IDLE, SEND, WAIT_ACK, WAIT_DONE, NEXT.
REQ-016 IDLE -> SEND when any pending bit is set and tx_busy=0; grant is driven from SEND until return to IDLE.
REQ-017 SHALL arbitrate round-robin: both pending in IDLE -> grant the requester not granted last; after reset, A wins first.
REQ-018 SHALL capture status_byte into an internal register at the IDLE->SEND transition for B; later changes are ignored for that message.
REQ-019 Message A SHALL be bytes 0x50,0x4F,0x4C,0x4F; message B SHALL be HDR_B, captured status byte.
REQ-020 SEND SHALL drive tx_data with the current byte and tx_start=1 for exactly one cycle, then go to WAIT_ACK.
REQ-021 WAIT_ACK SHALL wait for tx_busy=1, then go to WAIT_DONE; WAIT_DONE SHALL wait for tx_busy=0, then go to NEXT.
REQ-022 NEXT SHALL increment the byte index and go to SEND if bytes remain, else clear the owner's pending bit and return to IDLE.
REQ-023 tx_data SHALL remain stable from SEND until exit of WAIT_DONE.
REQ-024 Latency: req pulse in cycle N with FSM idle and tx_busy=0 -> tx_start high in cycle N+2.
REQ-025 Simultaneous req_a and req_b in the same cycle SHALL set both pending bits; no drop, no overflow.
REQ-026 A request for the non-owner during a transmission SHALL be queued and served immediately after (no message interleaving).

Reset
REQ-027 rst=1 SHALL force: state IDLE, pending bits 0, byte index 0, last-grant=B, tx_start=0, tx_data=8'h00, grant=2'b00, overflow=0.
REQ-028 Reset asserted mid-message SHALL abort the message without further tx_start; reset takes priority over req inputs in the same cycle.

Configuration
REQ-029 Macro UART_SCHED_CRLF_EN defined: every message SHALL be followed by 0x0D,0x0A (A=6 bytes, B=4 bytes).
REQ-030 Macro UART_SCHED_CRLF_EN undefined: messages SHALL be exactly as in REQ-019 (A=4, B=2 bytes), no CR/LF logic present.

Structure
REQ-031 Package uart_sched_pkg SHALL hold the FSM state typedef, the message A byte constants, and the CR/LF constants.
REQ-032 Sub-module uart_msg_rom SHALL map (owner, byte index, captured status) to the byte and a last-byte flag, combinationally.

Verification
REQ-033 req_a pulse, transmitter model raising busy 1 cycle after start for 10 cycles -> tx_start bytes 0x50,0x4F,0x4C,0x4F, grant=01 throughout, then 00.
REQ-034 req_a and req_b same cycle, status_byte=0xA5 -> full A message, then 0x53,0xA5; no overflow.
REQ-035 req_b during A's second byte, status_byte changed after grant -> B sent after A with value captured at grant.
REQ-036 Second req_a while A in WAIT_DONE -> overflow=1, A sent only once; overflow cleared only by rst.
REQ-037 rst asserted in WAIT_DONE of byte 2 -> all outputs at reset values next cycle; no further tx_start until new req.
REQ-038 With UART_SCHED_CRLF_EN: req_b, status 0x3C -> 0x53,0x3C,0x0D,0x0A; without it -> 0x53,0x3C only.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared FSM state type and message byte constants.
// Optional trailer: define UART_SCHED_CRLF_EN to append CR/LF to messages.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        NEXT
    } state_t;

    localparam logic [7:0] MSG_A_0 = 8'h50;
    localparam logic [7:0] MSG_A_1 = 8'h4F;
    localparam logic [7:0] MSG_A_2 = 8'h4C;
    localparam logic [7:0] MSG_A_3 = 8'h4F;

    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;

    function automatic logic [7:0] msg_a_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = MSG_A_0;
            3'd1:    b = MSG_A_1;
            3'd2:    b = MSG_A_2;
            3'd3:    b = MSG_A_3;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_msg_rom.sv
// uart_msg_rom: combinational (owner, index, status) -> byte + last flag.
// Define UART_SCHED_CRLF_EN to append CR/LF after every message.
module uart_msg_rom
    import uart_sched_pkg::*;
#(
    parameter int unsigned MSG_A_LEN = 4,
    parameter logic [7:0]  HDR_B     = 8'h53
) (
    input  logic       owner_b,
    input  logic [2:0] idx,
    input  logic [7:0] status,
    output logic [7:0] data,
    output logic       last
);

    localparam logic [2:0] A_END = 3'(MSG_A_LEN);

    // Byte lookup for the selected message and position
    always_comb begin
        data = 8'h00;
        last = 1'b0;
        if (owner_b) begin
`ifdef UART_SCHED_CRLF_EN
            case (idx)
                3'd0: data = HDR_B;
                3'd1: data = status;
                3'd2: data = CHR_CR;
                3'd3: begin
                    data = CHR_LF;
                    last = 1'b1;
                end
                default: data = 8'h00;
            endcase
`else
            case (idx)
                3'd0: data = HDR_B;
                3'd1: begin
                    data = status;
                    last = 1'b1;
                end
                default: data = 8'h00;
            endcase
`endif
        end else begin
`ifdef UART_SCHED_CRLF_EN
            if (idx < A_END) begin
                data = msg_a_byte(idx);
            end else if (idx == A_END) begin
                data = CHR_CR;
            end else if (idx == A_END + 3'd1) begin
                data = CHR_LF;
                last = 1'b1;
            end
`else
            if (idx < A_END) begin
                data = msg_a_byte(idx);
                last = (idx == A_END - 3'd1);
            end
`endif
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin scheduler of two canned UART messages.
// Define UART_SCHED_CRLF_EN to append CR/LF after every message.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned MSG_A_LEN = 4,
    parameter logic [7:0]  HDR_B     = 8'h53
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [7:0] status_byte,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [1:0] grant,
    output logic       overflow
);

    state_t     state;
    logic       pend_a;
    logic       pend_b;
    logic       last_b;
    logic       owner_b;
    logic       last_q;
    logic [2:0] idx;
    logic [7:0] status_q;

    logic       pick_b;
    logic       done;
    logic       rom_owner_b;
    logic [2:0] rom_idx;
    logic [7:0] rom_status;
    logic [7:0] rom_data;
    logic       rom_last;

    // B wins only if A is not pending or A was served last
    assign pick_b = pend_b & (~pend_a | ~last_b);
    assign done   = (state == NEXT) & last_q;

    // In IDLE the ROM looks ahead at the first byte of the winner
    assign rom_owner_b = (state == IDLE) ? pick_b : owner_b;
    assign rom_idx     = (state == IDLE) ? 3'd0 : idx + 3'd1;
    assign rom_status  = (state == IDLE) ? status_byte : status_q;

    uart_msg_rom #(
        .MSG_A_LEN(MSG_A_LEN),
        .HDR_B    (HDR_B)
    ) u_rom (
        .owner_b(rom_owner_b),
        .idx    (rom_idx),
        .status (rom_status),
        .data   (rom_data),
        .last   (rom_last)
    );

    // Pending bits and sticky overflow on duplicate requests
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (done & ~owner_b) pend_a <= 1'b0;
            if (done & owner_b)  pend_b <= 1'b0;
            if (req_a & ~pend_a) pend_a <= 1'b1;
            if (req_b & ~pend_b) pend_b <= 1'b1;
            if ((req_a & pend_a) | (req_b & pend_b))
                overflow <= 1'b1;
        end
    end

    // Message sequencer with registered transmitter outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 3'd0;
            last_b   <= 1'b1;
            owner_b  <= 1'b0;
            last_q   <= 1'b0;
            status_q <= 8'h00;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            grant    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if ((pend_a | pend_b) & ~tx_busy) begin
                        state    <= SEND;
                        owner_b  <= pick_b;
                        last_b   <= pick_b;
                        grant    <= pick_b ? 2'b10 : 2'b01;
                        idx      <= 3'd0;
                        tx_data  <= rom_data;
                        last_q   <= rom_last;
                        tx_start <= 1'b1;
                        if (pick_b) status_q <= status_byte;
                    end
                end
                SEND: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) state <= NEXT;
                end
                NEXT: begin
                    if (last_q) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        idx   <= 3'd0;
                    end else begin
                        state    <= SEND;
                        idx      <= idx + 3'd1;
                        tx_data  <= rom_data;
                        last_q   <= rom_last;
                        tx_start <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed bench with a busy-pulse transmitter model.
// Expected bytes follow UART_SCHED_CRLF_EN when it is defined.
module tb_uart_tx_scheduler;

    localparam logic [7:0] HDR = 8'h53;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [7:0] status_byte = 8'h00;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [1:0] grant;
    logic       overflow;

    uart_tx_scheduler #(
        .MSG_A_LEN(4),
        .HDR_B    (HDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .req_b      (req_b),
        .status_byte(status_byte),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .grant      (grant),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ra;
        logic       rb;
        logic [7:0] st;
        int         n;
        logic [7:0] b[10];
        logic [1:0] g[10];
    } vec_t;

    vec_t vec[7];

    int checks = 0;
    int errors = 0;

    logic [7:0] log_b[256];
    logic [1:0] log_g[256];
    int         n_log = 0;

    bit dly = 1'b0;
    int cnt = 0;

    // Transmitter model: busy rises one cycle after start, held 10 cycles
    always @(negedge clk) begin
        if (rst) begin
            tx_busy = 1'b0;
            dly = 1'b0;
            cnt = 0;
        end else begin
            if (cnt != 0) begin
                cnt = cnt - 1;
                if (cnt == 0) tx_busy = 1'b0;
            end
            if (dly) begin
                dly = 1'b0;
                tx_busy = 1'b1;
                cnt = 10;
            end
            if (tx_start) dly = 1'b1;
        end
    end

    // Log every byte handed to the transmitter with its grant
    always @(negedge clk) begin
        if (tx_start && n_log < 256) begin
            log_b[n_log] = tx_data;
            log_g[n_log] = grant;
            n_log = n_log + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ra, input logic rb);
        req_a = ra;
        req_b = rb;
        tick(1);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_log(input int target, input int maxc, input string nm);
        int c = 0;
        while (n_log < target && c < maxc) begin
            tick(1);
            c++;
        end
        chk(nm, int'(n_log >= target), 1);
    endtask

    task automatic wait_busy(input int maxc, input string nm);
        int c = 0;
        while (tx_busy !== 1'b1 && c < maxc) begin
            tick(1);
            c++;
        end
        chk(nm, int'(tx_busy), 1);
    endtask

    task automatic wait_grant(input logic [1:0] g, input int maxc, input string nm);
        int c = 0;
        while (grant !== g && c < maxc) begin
            tick(1);
            c++;
        end
        chk(nm, int'(grant), int'(g));
    endtask

    task automatic put(input int v, input logic [7:0] b, input logic [1:0] g);
        vec[v].b[vec[v].n] = b;
        vec[v].g[vec[v].n] = g;
        vec[v].n = vec[v].n + 1;
    endtask

    task automatic put_a(input int v);
        put(v, 8'h50, 2'b01);
        put(v, 8'h4F, 2'b01);
        put(v, 8'h4C, 2'b01);
        put(v, 8'h4F, 2'b01);
`ifdef UART_SCHED_CRLF_EN
        put(v, 8'h0D, 2'b01);
        put(v, 8'h0A, 2'b01);
`endif
    endtask

    task automatic put_b(input int v, input logic [7:0] st);
        put(v, HDR, 2'b10);
        put(v, st, 2'b10);
`ifdef UART_SCHED_CRLF_EN
        put(v, 8'h0D, 2'b10);
        put(v, 8'h0A, 2'b10);
`endif
    endtask

    task automatic check_msgs(input int base, input int v, input string nm);
        chk($sformatf("%s count", nm), n_log - base, vec[v].n);
        for (int i = 0; i < vec[v].n; i++) begin
            chk($sformatf("%s byte%0d", nm, i),
                int'(log_b[base + i]), int'(vec[v].b[i]));
            chk($sformatf("%s grant%0d", nm, i),
                int'(log_g[base + i]), int'(vec[v].g[i]));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int base2;

        for (int v = 0; v < 7; v++) begin
            vec[v].n  = 0;
            vec[v].ra = 1'b0;
            vec[v].rb = 1'b0;
            vec[v].st = 8'h00;
        end
        vec[0].ra = 1'b1;
        put_a(0);
        vec[1].ra = 1'b1;
        vec[1].rb = 1'b1;
        vec[1].st = 8'hA5;
        put_a(1);
        put_b(1, 8'hA5);
        vec[2].rb = 1'b1;
        vec[2].st = 8'h3C;
        put_b(2, 8'h3C);
        vec[3].rb = 1'b1;
        vec[3].st = 8'hFF;
        put_b(3, 8'hFF);
        put_b(4, 8'h11);
        put_a(4);
        put_a(5);
        put_b(5, 8'h5A);
        put_a(6);

        // reset values
        tick(2);
        @(negedge clk);
        chk("rst tx_start", int'(tx_start), 0);
        chk("rst tx_data", int'(tx_data), 0);
        chk("rst grant", int'(grant), 0);
        chk("rst overflow", int'(overflow), 0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // request-to-start latency
        base = n_log;
        pulse(1'b1, 1'b0);
        @(negedge clk);
        chk("lat start N+1", int'(tx_start), 0);
        @(negedge clk);
        chk("lat start N+2", int'(tx_start), 1);
        chk("lat data", int'(tx_data), 8'h50);
        chk("lat grant", int'(grant), 2'b01);
        tick(1);
        tick(150);
        check_msgs(base, 6, "lat");
        chk("lat idle grant", int'(grant), 0);

        // table-driven single-shot scenarios
        for (int i = 0; i < 4; i++) begin
            do_reset();
            status_byte = vec[i].st;
            base = n_log;
            pulse(vec[i].ra, vec[i].rb);
            tick(200);
            check_msgs(base, i, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d overflow", i), int'(overflow), 0);
            chk($sformatf("vec%0d grant", i), int'(grant), 0);
        end

        // round robin: A served last, so B wins a tie
        do_reset();
        pulse(1'b1, 1'b0);
        tick(100);
        base = n_log;
        status_byte = 8'h11;
        pulse(1'b1, 1'b1);
        tick(200);
        check_msgs(base, 4, "rr");

        // B queued during A, status captured at B's grant
        do_reset();
        base = n_log;
        status_byte = 8'h77;
        pulse(1'b1, 1'b0);
        wait_log(base + 2, 60, "cap wait byte1");
        status_byte = 8'h5A;
        pulse(1'b0, 1'b1);
        wait_grant(2'b10, 200, "cap wait grant b");
        status_byte = 8'hC3;
        tick(100);
        check_msgs(base, 5, "cap");
        chk("cap overflow", int'(overflow), 0);

        // duplicate A request while A in flight
        do_reset();
        base = n_log;
        pulse(1'b1, 1'b0);
        wait_log(base + 1, 20, "dup wait byte0");
        wait_busy(20, "dup wait busy");
        tick(3);
        pulse(1'b1, 1'b0);
        tick(200);
        check_msgs(base, 6, "dup");
        chk("dup overflow", int'(overflow), 1);
        tick(20);
        chk("dup overflow sticky", int'(overflow), 1);

        // reset in WAIT_DONE of the second byte
        do_reset();
        base = n_log;
        pulse(1'b1, 1'b0);
        wait_log(base + 2, 60, "abort wait byte1");
        wait_busy(20, "abort wait busy");
        tick(2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort tx_start", int'(tx_start), 0);
        chk("abort tx_data", int'(tx_data), 0);
        chk("abort grant", int'(grant), 0);
        chk("abort overflow", int'(overflow), 0);
        tick(1);
        rst = 1'b0;
        tick(100);
        chk("abort no restart", n_log - base, 2);
        base2 = n_log;
        pulse(1'b1, 1'b0);
        tick(150);
        check_msgs(base2, 6, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
